// File: rtl/barril_ctrl_pkg.sv
// Barrel sprite controller shared types and constants.
// Optional rotation animation: define BARRIL_ANIM_EN.
package barril_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL_R = 2'd1,
    ROLL_L = 2'd2,
    FALL   = 2'd3
  } state_t;

  localparam logic [1:0] DRAW_NONE   = 2'b00;
  localparam logic [1:0] DRAW_RED    = 2'b01;
  localparam logic [1:0] DRAW_ORANGE = 2'b10;
  localparam logic [1:0] DRAW_BLUE   = 2'b11;

  localparam logic [9:0] SPAWN_X = 10'd64;
  localparam logic [9:0] X_MIN   = 10'd16;
  localparam logic [9:0] X_MAX   = 10'd608;

  localparam logic [3:0][9:0] PLAT_Y = {
    10'd400, 10'd288, 10'd176, 10'd64
  };

  localparam logic [1:0] LAST_LEVEL = 2'd3;

  localparam logic [9:0] SPRITE_W = 10'd16;
  localparam logic [9:0] SPRITE_H = 10'd16;

  localparam logic [9:0] X_STEP = 10'd2;
  localparam logic [9:0] Y_STEP = 10'd4;

  localparam logic [2:0] ANIM_DIV_LAST = 3'd7;

  function automatic state_t roll_dir(
    input logic [1:0] lvl
  );
    return lvl[0] ? ROLL_L : ROLL_R;
  endfunction

endpackage

// File: rtl/barril_ctrl_if.sv
// Barrel controller bus: frame/position inputs from
// the video timing and sprite outputs to the colour mux.
interface barril_ctrl_if;
  logic       frame_tick;
  logic       spawn;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [1:0] barril_draw;
  logic       barril_active;
  logic [9:0] barril_x;
  logic [9:0] barril_y;

  modport master (
    output frame_tick, spawn, hcount, vcount,
    input  barril_draw, barril_active,
    input  barril_x, barril_y
  );

  modport slave (
    input  frame_tick, spawn, hcount, vcount,
    output barril_draw, barril_active,
    output barril_x, barril_y
  );
endinterface

// File: rtl/barril_rom.sv
// 16x16 barrel sprite, 2 bpp, combinational read.
// BARRIL_ANIM_EN adds frames 1-3 (bands rotate inward).
module barril_rom
  import barril_ctrl_pkg::*;
(
  input  logic [1:0] frame,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [1:0] px
);

  localparam logic [31:0] HOOP = 32'hAAAA_AAAA;
  localparam logic [31:0] BAND = 32'hFFFF_FFFF;
  localparam logic [31:0] BODY = 32'h9555_5556;

  logic [15:0][1:0] line;
  logic [3:0]       band_lo;
  logic [3:0]       band_hi;

`ifdef BARRIL_ANIM_EN
  assign band_lo = 4'd3 + {2'b00, frame};
  assign band_hi = 4'd12 - {2'b00, frame};
`else
  logic unused_frame;
  assign unused_frame = ^frame;
  assign band_lo = 4'd3;
  assign band_hi = 4'd12;
`endif

  always_comb begin
    line = BODY;
    if (row == 4'd0 || row == 4'd15)
      line = HOOP;
    else if (row == band_lo || row == band_hi)
      line = BAND;
  end

  // col 0 sits in the top bits of each row word
  assign px = line[4'd15 - col];

endmodule

// File: rtl/barril_ctrl.sv
// Rolling barrel FSM with registered sprite draw.
// Define BARRIL_ANIM_EN for the 4-frame rotation animation.
module barril_ctrl
  import barril_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  barril_ctrl_if.slave bus
);

  state_t     state;
  logic       active;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] level;
  logic [1:0] frame;
  logic [1:0] draw;

  logic [9:0] next_plat;
  logic [1:0] next_level;

  assign next_level = level + 2'd1;
  assign next_plat  = PLAT_Y[next_level];

`ifdef BARRIL_ANIM_EN
  logic [2:0] anim_cnt;
`else
  assign frame = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
      level  <= '0;
`ifdef BARRIL_ANIM_EN
      frame    <= '0;
      anim_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.spawn) begin
            state  <= ROLL_R;
            active <= 1'b1;
            x      <= SPAWN_X;
            y      <= PLAT_Y[0];
            level  <= '0;
`ifdef BARRIL_ANIM_EN
            frame    <= '0;
            anim_cnt <= '0;
`endif
          end
        end
        ROLL_R, ROLL_L: begin
          if (bus.frame_tick) begin
            if ((state == ROLL_R && x == X_MAX) ||
                (state == ROLL_L && x == X_MIN)) begin
              if (level == LAST_LEVEL) begin
                state  <= IDLE;
                active <= 1'b0;
              end else begin
                state <= FALL;
              end
            end else if (state == ROLL_R) begin
              x <= x + X_STEP;
            end else begin
              x <= x - X_STEP;
            end
`ifdef BARRIL_ANIM_EN
            anim_cnt <= anim_cnt + 3'd1;
            if (anim_cnt == ANIM_DIV_LAST)
              frame <= frame + 2'd1;
`endif
          end
        end
        FALL: begin
          if (bus.frame_tick) begin
            y <= y + Y_STEP;
            // landing: direction alternates per level
            if (y + Y_STEP == next_plat) begin
              level <= next_level;
              state <= roll_dir(next_level);
            end
          end
        end
      endcase
    end
  end

  logic [9:0] dx;
  logic [9:0] dy;
  logic       hit;
  logic [1:0] rom_px;

  assign dx  = bus.hcount - x;
  assign dy  = bus.vcount - y;
  assign hit = active &&
               bus.hcount >= x && dx < SPRITE_W &&
               bus.vcount >= y && dy < SPRITE_H;

  barril_rom u_rom (
    .frame (frame),
    .row   (dy[3:0]),
    .col   (dx[3:0]),
    .px    (rom_px)
  );

  always_ff @(posedge clk) begin
    if (rst)
      draw <= DRAW_NONE;
    else
      draw <= hit ? rom_px : DRAW_NONE;
  end

  assign bus.barril_draw   = draw;
  assign bus.barril_active = active;
  assign bus.barril_x      = x;
  assign bus.barril_y      = y;

endmodule
